// File: rtl/param_mux_pkg.sv
// Shared definitions for the packet multiplexer and its round-robin picker.
package param_mux_pkg;

   // Arbitration state: IDLE picks a channel, LOCK carries one packet from it.
   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } state_t;

   // Index width for N channels, never narrower than one bit.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/param_rr_arb.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping at N.
module param_rr_arb
   import param_mux_pkg::*;
#(
   parameter int N = 8,
   localparam int IW = clog2_min1(N)
)
(
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] gnt_idx,
   output logic          any
);

   logic [N-1:0] rot;
   int           pick;

   // Rotate requests so ptr sits at bit 0, find the lowest set bit, then rotate the index back.
   always_comb begin
      rot  = N'({req, req} >> ptr);
      pick = 0;
      any  = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) begin
            pick = i;
            any  = 1'b1;
         end
      end
      pick = pick + int'(ptr);
      if (pick >= N) begin
         pick = pick - N;
      end
      gnt_idx = IW'(pick);
   end

endmodule

// File: rtl/param_mux_arb.sv
// N-to-1 packet stream multiplexer with per-packet round-robin lock and a registered output.
module param_mux_arb
   import param_mux_pkg::*;
#(
   parameter int N = 8,
   parameter int W = 8,
   localparam int IW = clog2_min1(N)
)
(
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N*W-1:0] in_data,
   input  logic [N-1:0]   in_valid,
   input  logic [N-1:0]   in_last,
   output logic [N-1:0]   in_ready,
   output logic [W-1:0]   out_data,
   output logic           out_valid,
   output logic           out_last,
   output logic [IW-1:0]  out_sel,
   input  logic           out_ready
);

   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

   state_t        state;
   state_t        next_state;
   logic [IW-1:0] ptr;
   logic [IW-1:0] grant;
   logic [IW-1:0] arb_idx;
   logic          arb_any;
   logic [W-1:0]  chan_data [N];
   logic          can_accept;
   logic          accept;
   logic          accept_last;

   param_rr_arb #(.N(N)) u_arb (
      .req     (in_valid),
      .ptr     (ptr),
      .gnt_idx (arb_idx),
      .any     (arb_any)
   );

   // Split the flat data bus into per-channel words.
   always_comb begin
      for (int k = 0; k < N; k++) begin
         chan_data[k] = in_data[k*W +: W];
      end
   end

   // Next state and ready steering; only the locked channel may see ready, gated by output space.
   always_comb begin
      next_state  = state;
      in_ready    = '0;
      can_accept  = !out_valid || out_ready;
      accept      = 1'b0;
      accept_last = 1'b0;
      case (state)
         IDLE: begin
            if (arb_any) begin
               next_state = LOCK;
            end
         end
         LOCK: begin
            in_ready[grant] = can_accept;
            accept          = in_valid[grant] && can_accept;
            accept_last     = accept && in_last[grant];
            if (accept_last) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Grant is captured on arbitration; ptr moves past the winner once its packet ends.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr   <= '0;
         grant <= '0;
      end else begin
         if (state == IDLE && arb_any) begin
            grant <= arb_idx;
         end
         if (accept_last) begin
            ptr <= (grant == LAST_IDX) ? '0 : grant + IW'(1);
         end
      end
   end

   // Output register: load on an accepted beat, drop valid once the held beat is taken.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_sel   <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_data  <= chan_data[grant];
         out_last  <= in_last[grant];
         out_sel   <= grant;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
